// File: rtl/pronoc_pkg.sv
// pronoc_pkg: shared helpers and types for the tree NoC configuration path.
//  powi / sum_powi : integer power and geometric sum (router counts per tree).
//  tree_cfg_state_e: sequencer FSM states, also exported on the debug port.
//  tree_cfg_wr_t   : one config write {router_id, router_addr} for the
//                    default K=2, L=3 tree.
//  TREE_CFG_TO_MAX : stall counter limit used when TREE_CFG_TIMEOUT_EN is set.
package pronoc_pkg;

  function automatic int powi(input int x, input int y);
    int r;
    r = 1;
    for (int i = 0; i < y; i++) r = r * x;
    return r;
  endfunction

  // Total routers in a K-ary tree of y layers: sum of x^i for i < y.
  function automatic int sum_powi(input int x, input int y);
    int s;
    s = 0;
    for (int i = 0; i < y; i++) s = s + powi(x, i);
    return s;
  endfunction

  localparam logic [15:0] TREE_CFG_TO_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    CFG_IDLE  = 2'd0,
    CFG_ISSUE = 2'd1,
    CFG_DONE  = 2'd2
  } tree_cfg_state_e;

  typedef struct packed {
    logic [2:0] router_id;    // NR = 7 routers
    logic [4:0] router_addr;  // {layer[1:0], pos[2:0]}
  } tree_cfg_wr_t;

endpackage

// File: rtl/tree_kary_digit_counter.sv
// tree_kary_digit_counter: L-digit K-ary counter whose increment point is
// selectable. Adding 1 at digit inc_digit ripples carries toward digit L-1.
// A carry that would land in digit L-1 (including an increment aimed
// directly at digit L-1) is reported on carry_top and clears all digits,
// so digit L-1 always reads 0.
// Ports:
//  clk, reset    clock, synchronous active-low reset
//  inc           add 1 at digit inc_digit this cycle
//  inc_digit     digit index receiving the increment
//  clr           force all digits to 0 (wins over inc)
//  digits        {d[L-1], ..., d[0]}, Kw bits per digit
//  carry_top     inc this cycle carries into digit L-1
module tree_kary_digit_counter #(
  parameter int K  = 2,
  parameter int L  = 3,
  parameter int Kw = (K > 1) ? $clog2(K) : 1,
  parameter int Lw = (L > 1) ? $clog2(L) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic [Lw-1:0]   inc_digit,
  input  logic            clr,
  output logic [L*Kw-1:0] digits,
  output logic            carry_top
);

  logic [L*Kw-1:0] digits_q;
  logic [L*Kw-1:0] next_digits;
  logic            c;
  logic            cin;

  always_comb begin
    next_digits = digits_q;
    c           = 1'b0;
    cin         = 1'b0;
    // Digits below inc_digit see no carry-in; the chosen digit gets +1.
    for (int i = 0; i < L - 1; i++) begin
      cin = (Lw'(i) == inc_digit) ? 1'b1 : c;
      if (cin) begin
        if (digits_q[i*Kw +: Kw] == Kw'(K - 1)) begin
          next_digits[i*Kw +: Kw] = '0;
          c = 1'b1;
        end else begin
          next_digits[i*Kw +: Kw] = digits_q[i*Kw +: Kw] + Kw'(1);
          c = 1'b0;
        end
      end else begin
        c = 1'b0;
      end
    end
    carry_top = inc & ((inc_digit == Lw'(L - 1)) ? 1'b1 : c);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      digits_q <= '0;
    end else if (clr || carry_top) begin
      digits_q <= '0;
    end else if (inc) begin
      digits_q <= next_digits;
    end
  end

  assign digits = digits_q;

endmodule

// File: rtl/tree_cfg_sequencer.sv
// tree_cfg_sequencer: post-reset configuration walker for the tree NoC.
// After start it issues one write per router, root first, then layers
// L-2 down to 0 with pos ascending; router_id counts 0..NR-1.
// Optional feature macro: TREE_CFG_TIMEOUT_EN (stall timeout + cfg_timeout).
// Handshake: a write transfers on a cycle with cfg_valid & cfg_ready; while
// cfg_valid is high and cfg_ready low, id/addr hold and cfg_valid stays high.
// Ports:
//  clk, reset       clock, synchronous active-low reset
//  start            begin a sequence (only looked at in IDLE)
//  cfg_ready        sink accepts the current write
//  cfg_valid        write pending
//  cfg_router_id    target router id (0 when no write pending)
//  cfg_router_addr  {layer, pos code} (0 when no write pending)
//  busy             sequence in progress
//  done             one-cycle pulse after the last handshake (or timeout)
//  cfg_timeout      sticky stall-timeout flag (TREE_CFG_TIMEOUT_EN only)
//  state            FSM state for debug
module tree_cfg_sequencer
  import pronoc_pkg::*;
#(
  parameter int K   = 2,
  parameter int L   = 3,
  parameter int Kw  = (K > 1) ? $clog2(K) : 1,
  parameter int Lw  = (L > 1) ? $clog2(L) : 1,
  parameter int NRw = (sum_powi(K, L) > 1) ? $clog2(sum_powi(K, L)) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cfg_ready,
  output logic                 cfg_valid,
  output logic [NRw-1:0]       cfg_router_id,
  output logic [Lw+L*Kw-1:0]   cfg_router_addr,
  output logic                 busy,
  output logic                 done,
`ifdef TREE_CFG_TIMEOUT_EN
  output logic                 cfg_timeout,
`endif
  output tree_cfg_state_e      state
);

  tree_cfg_state_e state_q, state_d;
  logic [NRw-1:0]  id_q;
  logic [Lw-1:0]   layer_q;
  logic [L*Kw-1:0] digits;
  logic            carry_top;
  logic            hs;
  logic            start_ok;
  logic            last;
  logic            to_hit;

  assign hs       = cfg_valid & cfg_ready;
  assign start_ok = (state_q == CFG_IDLE) & start;
  // The final write is the one at the leaf layer that wraps the counter.
  assign last     = hs & carry_top & (layer_q == '0);

  tree_kary_digit_counter #(
    .K  (K),
    .L  (L),
    .Kw (Kw),
    .Lw (Lw)
  ) u_digits (
    .clk       (clk),
    .reset     (reset),
    .inc       (hs),
    .inc_digit (layer_q),
    .clr       (start_ok),
    .digits    (digits),
    .carry_top (carry_top)
  );

`ifdef TREE_CFG_TIMEOUT_EN
  logic [15:0] stall_q;
  logic        to_q;
  logic        stall;

  assign stall  = (state_q == CFG_ISSUE) & ~cfg_ready;
  // Fires on the stall cycle that brings the counter to TREE_CFG_TO_MAX.
  assign to_hit = stall & (stall_q == TREE_CFG_TO_MAX - 16'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      to_q    <= 1'b0;
    end else begin
      if (start_ok || hs) begin
        stall_q <= '0;
      end else if (stall) begin
        stall_q <= stall_q + 16'd1;
      end
      if (to_hit) to_q <= 1'b1;
    end
  end

  assign cfg_timeout = to_q;
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cfg_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        if (start) state_d = CFG_ISSUE;
      end
      CFG_ISSUE: begin
        cfg_valid = 1'b1;
        busy      = 1'b1;
        if (last || to_hit) state_d = CFG_DONE;
      end
      CFG_DONE: begin
        done    = 1'b1;
        state_d = CFG_IDLE;
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= CFG_IDLE;
      id_q    <= '0;
      layer_q <= Lw'(L - 1);
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        id_q    <= '0;
        layer_q <= Lw'(L - 1);
      end else if (hs) begin
        id_q <= id_q + NRw'(1);
        // Finished a layer: drop to the next one down (counter self-clears).
        if (carry_top && (layer_q != '0)) layer_q <= layer_q - Lw'(1);
      end
    end
  end

  // Bus fields read 0 when idle so the reset state shows all outputs low.
  assign cfg_router_id   = cfg_valid ? id_q : '0;
  assign cfg_router_addr = cfg_valid ? {layer_q, digits} : '0;
  assign state           = state_q;

endmodule

// File: tb/tb_tree_cfg_sequencer.sv
module tb_tree_cfg_sequencer;
  import pronoc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_a = 1'b0, ready_a = 1'b0;
  logic start_b = 1'b0, ready_b = 1'b0;
  logic valid_a, busy_a, done_a, valid_b, busy_b, done_b;
  logic [2:0] id_a, id_b;
  logic [4:0] addr_a, addr_b;
  tree_cfg_state_e state_a, state_b;
`ifdef TREE_CFG_TIMEOUT_EN
  logic to_a, to_b;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];

  // Hand-derived write sequences: {layer, pos code}.
  logic [4:0] tab_a [7] = '{5'b10_000, 5'b01_000, 5'b01_010, 5'b00_000,
                            5'b00_001, 5'b00_010, 5'b00_011};
  logic [4:0] tab_b [5] = '{5'b1_0000, 5'b0_0000, 5'b0_0001, 5'b0_0010,
                            5'b0_0011};

  always #5 clk = ~clk;

  tree_cfg_sequencer #(.K(2), .L(3)) u_a (
    .clk             (clk),
    .reset           (reset),
    .start           (start_a),
    .cfg_ready       (ready_a),
    .cfg_valid       (valid_a),
    .cfg_router_id   (id_a),
    .cfg_router_addr (addr_a),
    .busy            (busy_a),
    .done            (done_a),
`ifdef TREE_CFG_TIMEOUT_EN
    .cfg_timeout     (to_a),
`endif
    .state           (state_a)
  );

  tree_cfg_sequencer #(.K(4), .L(2)) u_b (
    .clk             (clk),
    .reset           (reset),
    .start           (start_b),
    .cfg_ready       (ready_b),
    .cfg_valid       (valid_b),
    .cfg_router_id   (id_b),
    .cfg_router_addr (addr_b),
    .busy            (busy_b),
    .done            (done_b),
`ifdef TREE_CFG_TIMEOUT_EN
    .cfg_timeout     (to_b),
`endif
    .state           (state_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic set_ready(input bit sel, input logic v);
    if (sel) ready_b = v; else ready_a = v;
  endtask

  task automatic push_a();
    for (int i = 0; i < 7; i++) exp_q.push_back({3'(i), tab_a[i]});
  endtask

  task automatic push_b();
    for (int i = 0; i < 5; i++) exp_q.push_back({3'(i), tab_b[i]});
  endtask

  // mode 0: ready held 1; mode 1: ready 1010... ; poke: extra starts while
  // busy and while in DONE.
  task automatic run_seq(input bit sel, input int nr, input int mode, input bit poke);
    int writes, dones, done_cyc;
    bit pv;
    logic [2:0] pid, id;
    logic [4:0] paddr, ad;
    logic v, b, d, rdy;
    logic [7:0] e;
    writes = 0; dones = 0; done_cyc = -1; pv = 1'b0; pid = '0; paddr = '0;
    set_ready(sel, 1'b1);
    set_start(sel, 1'b1);
    step();
    set_start(sel, 1'b0);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      set_ready(sel, rdy);
      if (poke) set_start(sel, (cyc == 3) || (cyc == nr + 1));
      v  = sel ? valid_b : valid_a;
      id = sel ? id_b : id_a;
      ad = sel ? addr_b : addr_a;
      b  = sel ? busy_b : busy_a;
      d  = sel ? done_b : done_a;
      if (pv) begin
        total++;
        if (v !== 1'b1 || id !== pid || ad !== paddr) begin
          bad++;
          $display("FAIL hold_stable cyc=%0d: got v=%b id=%0d addr=%b want v=1 id=%0d addr=%b",
                   cyc, v, id, ad, pid, paddr);
        end
      end
      if (writes < nr) begin
        total++;
        if (b !== 1'b1) begin
          bad++;
          $display("FAIL busy cyc=%0d: got %b want 1", cyc, b);
        end
      end
      if (v === 1'b1 && rdy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_write cyc=%0d: got id=%0d addr=%b want none", cyc, id, ad);
        end else begin
          e = exp_q.pop_front();
          if ({id, ad} !== e) begin
            bad++;
            $display("FAIL write cyc=%0d: got id=%0d addr=%b want id=%0d addr=%b",
                     cyc, id, ad, e[7:5], e[4:0]);
          end
        end
        if (mode == 0) begin
          total++;
          if (cyc != writes + 1) begin
            bad++;
            $display("FAIL write_cycle: got %0d want %0d", cyc, writes + 1);
          end
        end
        writes++;
      end
      if (d === 1'b1) begin
        dones++;
        done_cyc = cyc;
        total++;
        if (writes != nr) begin
          bad++;
          $display("FAIL done_early: got writes=%0d want %0d", writes, nr);
        end
      end
      pv = (v === 1'b1) && !rdy;
      pid = id;
      paddr = ad;
      step();
    end
    set_start(sel, 1'b0);
    total++;
    if (writes != nr) begin
      bad++;
      $display("FAIL write_count: got %0d want %0d", writes, nr);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL done_pulses: got %0d want 1", dones);
    end
    if (mode == 0) begin
      total++;
      if (done_cyc != nr + 1) begin
        bad++;
        $display("FAIL done_cycle: got %0d want %0d", done_cyc, nr + 1);
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    total++;
    if ({valid_a, busy_a, done_a, id_a, addr_a} !== 11'd0) begin
      bad++;
      $display("FAIL reset_a_outputs: got %b want 0", {valid_a, busy_a, done_a, id_a, addr_a});
    end
    total++;
    if ({valid_b, busy_b, done_b, id_b, addr_b} !== 11'd0) begin
      bad++;
      $display("FAIL reset_b_outputs: got %b want 0", {valid_b, busy_b, done_b, id_b, addr_b});
    end
    total++;
    if (state_a !== CFG_IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d", state_a, CFG_IDLE);
    end
`ifdef TREE_CFG_TIMEOUT_EN
    total++;
    if (to_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_timeout: got %b want 0", to_a);
    end
`endif
    reset = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    push_a();
    run_seq(1'b0, 7, 0, 1'b0);
  endtask

  task automatic test_k4_l2();
    push_b();
    run_seq(1'b1, 5, 0, 1'b0);
  endtask

  task automatic test_ready_toggle();
    push_a();
    run_seq(1'b0, 7, 1, 1'b0);
  endtask

  task automatic test_start_ignored();
    push_a();
    run_seq(1'b0, 7, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    ready_a = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    step();
    total++;
    if (valid_a !== 1'b1 || id_a !== 3'd3 || addr_a !== 5'b00_000) begin
      bad++;
      $display("FAIL mid_fourth_write: got v=%b id=%0d addr=%b want v=1 id=3 addr=00000",
               valid_a, id_a, addr_a);
    end
    reset = 1'b0;
    step();
    total++;
    if (valid_a !== 1'b0 || busy_a !== 1'b0 || id_a !== 3'd0 || addr_a !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b busy=%b id=%0d addr=%b want all 0",
               valid_a, busy_a, id_a, addr_a);
    end
    reset = 1'b1;
    step();
    total++;
    if (valid_a !== 1'b0) begin
      bad++;
      $display("FAIL mid_no_write: got v=%b want 0", valid_a);
    end
    push_a();
    run_seq(1'b0, 7, 0, 1'b0);
  endtask

`ifdef TREE_CFG_TIMEOUT_EN
  task automatic test_timeout();
    int done_cyc;
    done_cyc = -1;
    ready_a = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int cyc = 1; cyc <= 65600; cyc++) begin
      if (cyc == 65000) begin
        total++;
        if (valid_a !== 1'b1 || to_a !== 1'b0 || id_a !== 3'd0) begin
          bad++;
          $display("FAIL to_stalling: got v=%b to=%b id=%0d want v=1 to=0 id=0",
                   valid_a, to_a, id_a);
        end
      end
      if (done_a === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      step();
    end
    total++;
    if (done_cyc != 65536) begin
      bad++;
      $display("FAIL to_done_cycle: got %0d want 65536", done_cyc);
    end
    total++;
    if (to_a !== 1'b1 || valid_a !== 1'b0) begin
      bad++;
      $display("FAIL to_flag: got to=%b v=%b want to=1 v=0", to_a, valid_a);
    end
    step();
    push_a();
    run_seq(1'b0, 7, 0, 1'b0);
    total++;
    if (to_a !== 1'b1) begin
      bad++;
      $display("FAIL to_sticky: got %b want 1", to_a);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++;
    if (to_a !== 1'b0) begin
      bad++;
      $display("FAIL to_cleared: got %b want 0", to_a);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_k4_l2();
    test_ready_toggle();
    test_start_ignored();
    test_reset_mid();
`ifdef TREE_CFG_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
